// File: rtl/ycr_clk_gate_ctrl_if.sv
// ---------------------------------------------------------------------------
// ycr_clk_gate_ctrl_if
//
// Bundles the sleep/wake signalling between the core and the clock-gating
// controller, together with the controller's outputs toward the gate cell
// and the statistics counter.
//
// Signals
//   test_mode    DFT override, forces the core clock enabled
//   sleep_req    level sleep request from the core (WFI)
//   pipe_idle    pipeline and memory interfaces quiescent
//   wake_irq     pending enabled interrupt, level
//   wake_dbg     debug halt request, level
//   cnt_clr      synchronous clear of sleep_cycles
//   clk_en       enable to the clock-gate cell
//   sleep_ack    high while the core clock is gated
//   wake_done    one-cycle pulse when the clock has been restored
//   sleep_cycles count of cycles spent gated (saturating)
//
// Handshake: sleep_req is a level request and sleep_ack is its level
// acknowledge. The request is honoured only once the pipeline has been idle
// long enough; sleep_ack then stays high for as long as the clock is gated,
// independent of sleep_req, and drops on the same edge that re-enables the
// clock. wake_irq/wake_dbg are levels and need no acknowledge: wake_done
// marks the first normal cycle after the clock is restored.
//
// Modports
//   master  core/system side driving requests
//   slave   the controller
// ---------------------------------------------------------------------------
interface ycr_clk_gate_ctrl_if;
  logic        test_mode;
  logic        sleep_req;
  logic        pipe_idle;
  logic        wake_irq;
  logic        wake_dbg;
  logic        cnt_clr;
  logic        clk_en;
  logic        sleep_ack;
  logic        wake_done;
  logic [31:0] sleep_cycles;

  modport master (
    output test_mode,
    output sleep_req,
    output pipe_idle,
    output wake_irq,
    output wake_dbg,
    output cnt_clr,
    input  clk_en,
    input  sleep_ack,
    input  wake_done,
    input  sleep_cycles
  );

  modport slave (
    input  test_mode,
    input  sleep_req,
    input  pipe_idle,
    input  wake_irq,
    input  wake_dbg,
    input  cnt_clr,
    output clk_en,
    output sleep_ack,
    output wake_done,
    output sleep_cycles
  );
endinterface

// File: rtl/ycr_clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// ycr_clk_gate_ctrl
//
// Clock-gating controller for the core clock. Runs on the free-running clock
// and drives the enable of the core clock-gate cell. The core clock is
// stopped after a sleep request once the pipeline has been quiescent for
// IDLE_DLY consecutive cycles, and restarted on an interrupt or debug wake
// event. After restart the clock runs WAKE_DLY cycles before wake_done pulses.
//
// Parameters
//   IDLE_DLY  consecutive idle cycles in DRAIN before gating (1..255)
//   WAKE_DLY  cycles spent in WAKE before wake_done (1..255)
//
// Ports
//   clk          free-running (ungated) clock
//   rst_n        asynchronous active-low reset
//   gate_if      slave side of ycr_clk_gate_ctrl_if (requests in, enable,
//                acknowledge, wake pulse and statistics out)
//   dbg_state_o  current controller state:
//                0 = RUN, 1 = DRAIN, 2 = SLEEP, 3 = WAKE
// ---------------------------------------------------------------------------
module ycr_clk_gate_ctrl #(
  parameter int unsigned IDLE_DLY = 4,
  parameter int unsigned WAKE_DLY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  ycr_clk_gate_ctrl_if.slave gate_if,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  // Terminal values of the shared DRAIN/WAKE counter.
  localparam logic [7:0] IDLE_LAST = 8'(IDLE_DLY - 1);
  localparam logic [7:0] WAKE_LAST = 8'(WAKE_DLY - 1);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  state_e      state_q;
  logic [7:0]  dcnt_q;
  logic        gate_q;
  logic        wake_done_q;
  logic [31:0] sleep_cycles_q;

  logic        wake;
  logic        leave_req;

  assign wake = gate_if.wake_irq | gate_if.wake_dbg;

  // Anything that cancels an in-progress drain (or prevents one starting).
  assign leave_req = ~gate_if.sleep_req | wake | gate_if.test_mode;

  // -------------------------------------------------------------------------
  // Controller FSM. gate_q is set on the same edge that enters SLEEP and
  // cleared on the edge that leaves it, so it is high exactly while the
  // state is SLEEP and clk_en only ever moves on a rising clk edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      dcnt_q      <= 8'd0;
      gate_q      <= 1'b0;
      wake_done_q <= 1'b0;
    end else begin
      wake_done_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          // A pending wake holds the core running even with sleep_req set.
          if (!leave_req) begin
            state_q <= ST_DRAIN;
            dcnt_q  <= 8'd0;
          end
        end

        ST_DRAIN: begin
          // Cancellation wins over the final idle count, so a wake on the
          // last drain cycle never produces a gated cycle.
          if (leave_req) begin
            state_q <= ST_RUN;
          end else if (!gate_if.pipe_idle) begin
            // Any busy cycle restarts the full idle window.
            dcnt_q <= 8'd0;
          end else if (dcnt_q == IDLE_LAST) begin
            state_q <= ST_SLEEP;
            gate_q  <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + 8'd1;
          end
        end

        ST_SLEEP: begin
          // sleep_req/pipe_idle come from the frozen core and are ignored.
          if (wake || gate_if.test_mode) begin
            state_q <= ST_WAKE;
            dcnt_q  <= 8'd0;
            gate_q  <= 1'b0;
          end
        end

        ST_WAKE: begin
          // Further wake events are irrelevant here; the clock is running.
          dcnt_q <= dcnt_q + 8'd1;
          if (dcnt_q == WAKE_LAST) begin
            state_q     <= ST_RUN;
            wake_done_q <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_RUN;
          dcnt_q  <= 8'd0;
          gate_q  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Gated-cycle statistics. Clear wins over increment; the count sticks at
  // all-ones instead of wrapping.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sleep_cycles_q <= 32'd0;
    end else if (gate_if.cnt_clr) begin
      sleep_cycles_q <= 32'd0;
    end else if (state_q == ST_SLEEP && sleep_cycles_q != CNT_MAX) begin
      sleep_cycles_q <= sleep_cycles_q + 32'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. test_mode is ORed in combinationally so scan can force the
  // clock on in the same cycle; reset clears gate_q asynchronously, which
  // re-enables the clock without needing an edge.
  // -------------------------------------------------------------------------
  assign gate_if.clk_en       = ~gate_q | gate_if.test_mode;
  assign gate_if.sleep_ack    = gate_q;
  assign gate_if.wake_done    = wake_done_q;
  assign gate_if.sleep_cycles = sleep_cycles_q;
  assign dbg_state_o          = state_q;

endmodule
